// File: rtl/plic_prio.sv
// plic_prio: memory-mapped platform interrupt controller.
// Each source has a priority and an enable bit, and is either edge- or level-triggered.
// A global threshold filters low-priority sources. Claim and complete gate each source.
// Ports:
//   clk, rst_n     - system clock (posedge) and asynchronous active-low reset
//   irqs           - interrupt source lines [INTR_NUM-1:1], synchronous to clk
//   has_req        - high while a claimable source exists
//   addr_bus       - byte address of the shared bus
//   data_bus       - bidirectional data; driven only during a read hit
//   rd_bus, wr_bus - read and write strobes, held until fc_bus is seen
//   data_mask_bus  - byte-lane enables for writes
//   fc_bus         - function complete; released (z) when the address misses
module plic_prio #(
    parameter logic [31:0] START_ADDR = 32'h0,
    parameter int          INTR_NUM   = 16,
    parameter int          PRIO_BITS  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [INTR_NUM-1:1] irqs,
    output logic                has_req,
    input  logic [31:0]         addr_bus,
    inout  wire  [31:0]         data_bus,
    input  logic                rd_bus,
    input  logic                wr_bus,
    input  logic [3:0]          data_mask_bus,
    output wire                 fc_bus
);

    // Valid per-source bits are 1..INTR_NUM-1; ID 0 is reserved.
    localparam logic [63:0] ALL_SRC_64 = (64'd1 << INTR_NUM) - 64'd1;
    localparam logic [31:0] SRC_MASK   = ALL_SRC_64[31:0] & 32'hFFFF_FFFE;

    localparam logic [3:0] IDX_PENDING   = 4'd0;
    localparam logic [3:0] IDX_ENABLE    = 4'd1;
    localparam logic [3:0] IDX_THRESHOLD = 4'd2;
    localparam logic [3:0] IDX_CLAIM     = 4'd3;
    localparam logic [3:0] IDX_MODE      = 4'd4;
    localparam logic [3:0] IDX_INSERVICE = 4'd5;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_READ       = 2'd1,
        ST_WRITE_DONE = 2'd2
    } state_t;

    function automatic logic [31:0] lane_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    state_t               state_r, state_nxt_s;
    logic [3:0]           idx_r;
    logic [4:0]           claim_id_r;
    logic [31:0]          pending_r, enable_r, mode_r, inservice_r, irq_d_r;
    logic [PRIO_BITS-1:0] threshold_r;
    logic [PRIO_BITS-1:0] prio_r [32];

    logic [31:0]          offset_s, wval_s, irq_s, rise_s, pend_nxt_s, inserv_nxt_s, rdata_s;
    logic [3:0]           idx_s;
    logic                 hit_s, write_fire_s, read_start_s, claim_fire_s, drive_s;
    logic [4:0]           best_id_s;
    logic [PRIO_BITS-1:0] best_prio_s;

    assign offset_s     = addr_bus - START_ADDR;
    assign hit_s        = (offset_s < 32'd64);
    assign idx_s        = offset_s[5:2];
    assign wval_s       = data_bus & lane_mask(data_mask_bus);
    assign irq_s        = 32'({irqs, 1'b0});
    assign write_fire_s = (state_r == ST_IDLE) && wr_bus && hit_s;
    assign read_start_s = (state_r == ST_IDLE) && rd_bus && hit_s && !write_fire_s;
    // The claim takes effect when the CPU ends the CLAIM read, not when it starts it.
    assign claim_fire_s = (state_r == ST_READ) && !rd_bus && (idx_r == IDX_CLAIM)
                          && (claim_id_r != 5'd0);

    // The bus is released while reset is asserted, even if a strobe is still high.
    assign drive_s  = rd_bus && hit_s && rst_n;
    assign data_bus = drive_s ? rdata_s : 32'bz;
    assign fc_bus   = (hit_s && rst_n) ? (drive_s || (state_r == ST_WRITE_DONE)) : 1'bz;
    assign has_req  = (best_id_s != 5'd0);

    // Bus FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (write_fire_s) begin
                    state_nxt_s = ST_WRITE_DONE;
                end else if (read_start_s) begin
                    state_nxt_s = ST_READ;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (!rd_bus) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_READ;
                end
            end
            ST_WRITE_DONE: begin
                if (!wr_bus) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WRITE_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Next pending and in-service vectors.
    // A new edge beats a claim on the same source in the same cycle.
    always_comb begin
        rise_s       = irq_s & ~irq_d_r;
        pend_nxt_s   = pending_r;
        inserv_nxt_s = inservice_r;
        for (int i = 1; i < 32; i++) begin
            if (mode_r[i]) begin
                if (inservice_r[i]) begin
                    pend_nxt_s[i] = pending_r[i];
                end else begin
                    pend_nxt_s[i] = irq_s[i];
                end
            end else if (rise_s[i]) begin
                pend_nxt_s[i] = 1'b1;
            end else if (claim_fire_s && (claim_id_r == 5'(i))) begin
                pend_nxt_s[i] = 1'b0;
            end else begin
                pend_nxt_s[i] = pending_r[i];
            end

            if (claim_fire_s && (claim_id_r == 5'(i))) begin
                inserv_nxt_s[i] = 1'b1;
            end else if (write_fire_s && (idx_s == IDX_CLAIM) && (wval_s == 32'(i))) begin
                inserv_nxt_s[i] = 1'b0;
            end else begin
                inserv_nxt_s[i] = inservice_r[i];
            end
        end
        pend_nxt_s   = pend_nxt_s & SRC_MASK;
        inserv_nxt_s = inserv_nxt_s & SRC_MASK;
    end

    // Best-ID arbitration.
    // The scan runs from high index to low and uses >=, so the lowest index wins a tie.
    always_comb begin
        best_id_s   = 5'd0;
        best_prio_s = '0;
        for (int i = INTR_NUM - 1; i >= 1; i--) begin
            if (pending_r[i] && enable_r[i] && !inservice_r[i]
                && (prio_r[i] > threshold_r) && (prio_r[i] >= best_prio_s)) begin
                best_id_s   = 5'(i);
                best_prio_s = prio_r[i];
            end else begin
                best_id_s   = best_id_s;
                best_prio_s = best_prio_s;
            end
        end
    end

    // Read-data multiplexer.
    // During a CLAIM read, the ID latched at the start of the read is returned.
    always_comb begin
        rdata_s = 32'd0;
        case (idx_s)
            IDX_PENDING:   rdata_s = pending_r;
            IDX_ENABLE:    rdata_s = enable_r;
            IDX_THRESHOLD: rdata_s = 32'(threshold_r);
            IDX_CLAIM:     rdata_s = (state_r == ST_READ) ? 32'(claim_id_r) : 32'(best_id_s);
            IDX_MODE:      rdata_s = mode_r;
            IDX_INSERVICE: rdata_s = inservice_r;
            default: begin
                if (idx_s[3]) begin
                    for (int b = 0; b < 4; b++) begin
                        rdata_s[8*b +: 8] = 8'(prio_r[{idx_s[2:0], 2'(b)}]);
                    end
                end else begin
                    rdata_s = 32'd0;
                end
            end
        endcase
    end

    // FSM state, read latches, pending, in-service and the edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            idx_r       <= 4'd0;
            claim_id_r  <= 5'd0;
            pending_r   <= 32'd0;
            inservice_r <= 32'd0;
            irq_d_r     <= 32'd0;
        end else begin
            state_r     <= state_nxt_s;
            pending_r   <= pend_nxt_s;
            inservice_r <= inserv_nxt_s;
            irq_d_r     <= irq_s;
            if (read_start_s) begin
                idx_r      <= idx_s;
                claim_id_r <= best_id_s;
            end
        end
    end

    // Byte-masked writes to the RW registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enable_r    <= 32'd0;
            mode_r      <= 32'd0;
            threshold_r <= '0;
            for (int i = 0; i < 32; i++) begin
                prio_r[i] <= '0;
            end
        end else if (write_fire_s) begin
            case (idx_s)
                IDX_ENABLE: enable_r <= ((enable_r & ~lane_mask(data_mask_bus)) | wval_s) & SRC_MASK;
                IDX_MODE:   mode_r   <= ((mode_r & ~lane_mask(data_mask_bus)) | wval_s) & SRC_MASK;
                IDX_THRESHOLD: begin
                    if (data_mask_bus[0]) begin
                        threshold_r <= data_bus[PRIO_BITS-1:0];
                    end
                end
                default: begin
                    if (idx_s[3]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (data_mask_bus[b] && SRC_MASK[{idx_s[2:0], 2'(b)}]) begin
                                prio_r[{idx_s[2:0], 2'(b)}] <= data_bus[8*b +: PRIO_BITS];
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_plic_prio.sv
// tb_plic_prio: directed, self-checking bench for plic_prio.
// Expected read data is queued when a read is issued.
// It is popped and compared when the DUT completes that read.
module tb_plic_prio;

    localparam logic [31:0] A_PEND  = 32'h00;
    localparam logic [31:0] A_EN    = 32'h04;
    localparam logic [31:0] A_THR   = 32'h08;
    localparam logic [31:0] A_CLAIM = 32'h0C;
    localparam logic [31:0] A_MODE  = 32'h10;
    localparam logic [31:0] A_INSV  = 32'h14;
    localparam logic [31:0] A_UNUSED = 32'h18;
    localparam logic [31:0] A_PRIO0 = 32'h20;
    localparam logic [31:0] A_PRIO1 = 32'h24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:1] irqs;
    logic        has_req;
    logic [31:0] addr_bus;
    wire  [31:0] data_bus;
    logic        rd_bus;
    logic        wr_bus;
    logic [3:0]  data_mask_bus;
    wire         fc_bus;

    logic [31:0] tb_data;
    logic        tb_drive;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    // A released data bus reads all ones; a released fc_bus reads 0.
    assign data_bus = tb_drive ? tb_data : 32'bz;
    pullup   pu_data (data_bus);
    pulldown pd_fc   (fc_bus);

    always #5 clk = ~clk;

    plic_prio #(.START_ADDR(32'h0), .INTR_NUM(16), .PRIO_BITS(3)) dut (
        .clk(clk), .rst_n(rst_n), .irqs(irqs), .has_req(has_req),
        .addr_bus(addr_bus), .data_bus(data_bus), .rd_bus(rd_bus), .wr_bus(wr_bus),
        .data_mask_bus(data_mask_bus), .fc_bus(fc_bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_fc(input string tag);
        bit got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (fc_bus === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) check({tag, "_fc_timeout"}, 32'(fc_bus), 32'd1);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        @(negedge clk);
        addr_bus = a; tb_data = d; tb_drive = 1'b1; data_mask_bus = m; wr_bus = 1'b1;
        wait_fc("write");
        wr_bus = 1'b0; tb_drive = 1'b0; data_mask_bus = 4'hF;
        @(negedge clk);
    endtask

    task automatic read_expect(input string tag, input logic [31:0] a, input logic [31:0] e);
        logic [31:0] d;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        addr_bus = a; rd_bus = 1'b1;
        wait_fc(tag);
        d = data_bus;
        rd_bus = 1'b0;
        @(negedge clk);
        check(tag_q.pop_front(), d, exp_q.pop_front());
    endtask

    task automatic pulse_irq(input int src);
        @(negedge clk);
        irqs[src] = 1'b1;
        @(negedge clk);
        irqs[src] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; irqs = '0; addr_bus = 32'd0; rd_bus = 1'b0; wr_bus = 1'b0;
        data_mask_bus = 4'hF; tb_data = 32'd0; tb_drive = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_has_req", 32'(has_req), 32'd0);

        // 1. Reset in the middle of a CLAIM read.
        bus_write(A_EN, 32'h0000_FFFF, 4'hF);
        bus_write(A_PRIO0, 32'h0101_0100, 4'hF);
        pulse_irq(1);
        check("pre_reset_has_req", 32'(has_req), 32'd1);
        @(negedge clk);
        addr_bus = A_CLAIM; rd_bus = 1'b1;
        @(negedge clk);
        check("mid_read_fc", 32'(fc_bus), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_has_req", 32'(has_req), 32'd0);
        check("rst_data_released", data_bus, 32'hFFFF_FFFF);
        check("rst_fc_released", 32'(fc_bus), 32'd0);
        @(negedge clk);
        rd_bus = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        read_expect("rst_pending", A_PEND, 32'd0);
        read_expect("rst_enable", A_EN, 32'd0);
        read_expect("rst_threshold", A_THR, 32'd0);
        read_expect("rst_mode", A_MODE, 32'd0);
        read_expect("rst_inservice", A_INSV, 32'd0);
        read_expect("rst_prio0", A_PRIO0, 32'd0);
        read_expect("rst_claim", A_CLAIM, 32'd0);

        // 2. Priority ordering and tie-break.
        bus_write(A_PRIO1, 32'h0500_0500, 4'hF);
        bus_write(A_PRIO0, 32'h0200_0000, 4'hF);
        bus_write(A_EN, 32'h0000_00A8, 4'hF);
        @(negedge clk);
        irqs[3] = 1'b1; irqs[5] = 1'b1; irqs[7] = 1'b1;
        @(negedge clk);
        irqs = '0;
        check("prio_has_req", 32'(has_req), 32'd1);
        read_expect("claim_first_5", A_CLAIM, 32'd5);
        read_expect("claim_tie_7", A_CLAIM, 32'd7);
        read_expect("claim_low_3", A_CLAIM, 32'd3);
        check("prio_has_req_done", 32'(has_req), 32'd0);
        read_expect("inservice_357", A_INSV, 32'h0000_00A8);
        bus_write(A_CLAIM, 32'd5, 4'hF);
        bus_write(A_CLAIM, 32'd7, 4'hF);
        bus_write(A_CLAIM, 32'd3, 4'hF);
        read_expect("inservice_cleared", A_INSV, 32'd0);

        // 3. Threshold.
        bus_write(A_THR, 32'd4, 4'b0001);
        bus_write(A_PRIO0, 32'h0204_0000, 4'hF);
        bus_write(A_EN, 32'h0000_00AC, 4'hF);
        pulse_irq(2);
        check("thr_equal_blocks", 32'(has_req), 32'd0);
        bus_write(A_THR, 32'd3, 4'b0001);
        check("thr_below_passes", 32'(has_req), 32'd1);
        read_expect("thr_claim_2", A_CLAIM, 32'd2);
        bus_write(A_CLAIM, 32'd2, 4'hF);
        bus_write(A_THR, 32'd0, 4'b0001);

        // 4. Claim/complete gating.
        bus_write(A_PRIO1, 32'h0500_0501, 4'hF);
        bus_write(A_EN, 32'h0000_00BC, 4'hF);
        pulse_irq(4);
        check("gate_has_req", 32'(has_req), 32'd1);
        read_expect("gate_claim_4", A_CLAIM, 32'd4);
        pulse_irq(4);
        check("gate_blocked", 32'(has_req), 32'd0);
        read_expect("gate_pending4", A_PEND, 32'h0000_0010);
        bus_write(A_CLAIM, 32'd4, 4'hF);
        check("gate_released", 32'(has_req), 32'd1);
        read_expect("gate_reclaim_4", A_CLAIM, 32'd4);
        bus_write(A_CLAIM, 32'd4, 4'hF);
        check("gate_idle", 32'(has_req), 32'd0);

        // 5. Level mode.
        bus_write(A_MODE, 32'h0000_0040, 4'hF);
        bus_write(A_PRIO1, 32'h0503_0501, 4'hF);
        bus_write(A_EN, 32'h0000_00FC, 4'hF);
        @(negedge clk);
        irqs[6] = 1'b1;
        @(negedge clk);
        check("level_has_req", 32'(has_req), 32'd1);
        read_expect("level_claim_6", A_CLAIM, 32'd6);
        check("level_in_service", 32'(has_req), 32'd0);
        read_expect("level_pending_held", A_PEND, 32'h0000_0040);
        bus_write(A_CLAIM, 32'd6, 4'hF);
        check("level_reassert", 32'(has_req), 32'd1);
        irqs[6] = 1'b0;
        @(negedge clk);
        check("level_drop_has_req", 32'(has_req), 32'd0);
        read_expect("level_pending_clear", A_PEND, 32'd0);
        read_expect("claim_empty", A_CLAIM, 32'd0);
        read_expect("claim_empty_no_effect", A_INSV, 32'd0);
        bus_write(A_CLAIM, 32'd0, 4'hF);
        read_expect("complete_zero_ignored", A_INSV, 32'd0);

        // 6. Byte masks, unused bits and address decode.
        bus_write(A_EN, 32'hFFFF_FFFF, 4'b0001);
        read_expect("mask_lane0", A_EN, 32'h0000_00FE);
        bus_write(A_EN, 32'hFFFF_FFFF, 4'b1111);
        read_expect("mask_all_src", A_EN, 32'h0000_FFFE);
        bus_write(A_PRIO1, 32'h0000_0000, 4'b0100);
        read_expect("prio_lane2_only", A_PRIO1, 32'h0500_0501);
        read_expect("unused_word", A_UNUSED, 32'd0);
        @(negedge clk);
        addr_bus = 32'h0000_0100; rd_bus = 1'b1;
        @(negedge clk);
        check("miss_fc_released", 32'(fc_bus), 32'd0);
        check("miss_data_released", data_bus, 32'hFFFF_FFFF);
        rd_bus = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
